note_sequencer: RTL and testbench

Song playback sequencer that reads the per-song note-duration ROMs. It drives `note_index` into the duration ROM (and the parallel pitch ROM), samples the returned `note_dur` cycle count, and times each note. It emits a gated `note_on` to the tone generator, with a fixed articulation gap at the end of every note. It supports play, stop, pause and looping, and sits between the song-select/control logic and the tone generator.

---
 rtl/note_sequencer.sv | 152 +++++++++++++++
 tb/tb_note_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Song note sequencer: walks the duration ROM by note_index, times PLAY/GAP per note, gates note_on.
// Outputs registered (1 cycle after decision); pause freezes note timing, stop aborts at once.
module note_sequencer #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int GAP_CYCLES = CLOCK_FREQ / 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        stop,
  input  logic        pause,
  input  logic        loop_en,
  input  logic [10:0] song_len,
  input  logic [28:0] note_dur,
  output logic [10:0] note_index,
  output logic        note_on,
  output logic        note_start,
  output logic        song_done,
  output logic        busy
);

  localparam logic [28:0] GAP_W = 29'(GAP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t      r_state;
  logic [10:0] r_idx;
  logic [10:0] r_len;
  logic [28:0] r_cnt;
  logic [28:0] r_off;
  logic        r_note_on;
  logic        r_note_start;
  logic        r_song_done;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [10:0] w_idx_nxt;
  logic [10:0] w_len_nxt;
  logic [28:0] w_cnt_nxt;
  logic [28:0] w_off_nxt;
  logic        w_done_nxt;
  logic        w_adv;
  logic [28:0] w_dur;
  logic [28:0] w_on_len;
  logic [28:0] w_off_len;

  // A zero-length note still sounds for one cycle; short notes keep at least one on-cycle.
  assign w_dur     = (note_dur == 29'd0) ? 29'd1 : note_dur;
  assign w_on_len  = (w_dur > GAP_W) ? (w_dur - GAP_W) : 29'd1;
  assign w_off_len = w_dur - w_on_len;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_off_nxt   = r_off;
    w_done_nxt  = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (play) begin
          if (song_len != 11'd0) begin
            w_len_nxt   = song_len;
            w_idx_nxt   = 11'd0;
            w_state_nxt = S_LOAD;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_cnt_nxt   = w_on_len;
        w_off_nxt   = w_off_len;
        w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (!pause) begin
          if (r_cnt == 29'd1) begin
            if (r_off != 29'd0) begin
              w_cnt_nxt   = r_off;
              w_state_nxt = S_GAP;
            end else begin
              w_adv = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt - 29'd1;
          end
        end
      end
      S_GAP: begin
        if (!pause) begin
          if (r_cnt == 29'd1) w_adv = 1'b1;
          else                w_cnt_nxt = r_cnt - 29'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_adv) begin
      if (r_idx != r_len - 11'd1) begin
        w_idx_nxt   = r_idx + 11'd1;
        w_state_nxt = S_LOAD;
      end else if (loop_en) begin
        w_idx_nxt   = 11'd0;
        w_state_nxt = S_LOAD;
      end else begin
        w_idx_nxt   = 11'd0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    end

    // Abort overrides everything except reset, and never reports completion.
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 11'd0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= 11'd0;
      r_len        <= 11'd0;
      r_cnt        <= 29'd0;
      r_off        <= 29'd0;
      r_note_on    <= 1'b0;
      r_note_start <= 1'b0;
      r_song_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_len        <= w_len_nxt;
      r_cnt        <= w_cnt_nxt;
      r_off        <= w_off_nxt;
      r_note_on    <= (w_state_nxt == S_PLAY) && !pause;
      r_note_start <= (r_state == S_LOAD) && (w_state_nxt == S_PLAY);
      r_song_done  <= w_done_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign note_index = r_idx;
  assign note_on    = r_note_on;
  assign note_start = r_note_start;
  assign song_done  = r_song_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (gap 2 and gap 0) checked against a progress-based note model,
// plus vector tables and directed sequences for pause, loop, stop, edge inputs and reset mid-gap.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst, play, stop, pause, loop_en;
  logic [10:0] song_len;
  logic [28:0] rom [16];

  logic [10:0] w_idx  [2];
  logic        w_on   [2];
  logic        w_st   [2];
  logic        w_done [2];
  logic        w_busy [2];
  logic [28:0] w_dur  [2];

  int n_chk = 0;
  int n_err = 0;

  int gap_of [2] = '{2, 0};
  int m_busy [2], m_idx [2], m_len [2], m_t [2], m_d [2], m_on [2];
  int e_on [2], e_st [2], e_done [2];

  typedef struct {
    bit play, stop, pause, loop_en;
    int len, idx;
    bit on, st, done, busy;
  } vec_t;
  vec_t vt[$];

  assign w_dur[0] = rom[w_idx[0][3:0]];
  assign w_dur[1] = rom[w_idx[1][3:0]];

  always #5 clk = ~clk;

  note_sequencer #(.CLOCK_FREQ(200), .GAP_CYCLES(2)) u_g2 (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .pause(pause), .loop_en(loop_en),
    .song_len(song_len), .note_dur(w_dur[0]), .note_index(w_idx[0]), .note_on(w_on[0]),
    .note_start(w_st[0]), .song_done(w_done[0]), .busy(w_busy[0])
  );

  note_sequencer #(.CLOCK_FREQ(0), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst(rst), .play(play), .stop(stop), .pause(pause), .loop_en(loop_en),
    .song_len(song_len), .note_dur(w_dur[1]), .note_index(w_idx[1]), .note_on(w_on[1]),
    .note_start(w_st[1]), .song_done(w_done[1]), .busy(w_busy[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t is progress through the note (0 = load, 1..on = sounding, on+1..d = gap).
  task automatic model_step(input int k);
    int g;
    g = gap_of[k];
    e_st[k] = 0;
    e_done[k] = 0;
    if (rst) begin
      m_busy[k] = 0; m_idx[k] = 0; m_t[k] = 0;
    end else if (stop) begin
      m_busy[k] = 0; m_idx[k] = 0;
    end else if (m_busy[k] == 0) begin
      if (play) begin
        if (song_len != 0) begin
          m_len[k] = int'(song_len); m_idx[k] = 0; m_busy[k] = 1; m_t[k] = 0;
        end else begin
          e_done[k] = 1;
        end
      end
    end else if (m_t[k] == 0) begin
      m_d[k] = (rom[m_idx[k] % 16] == 0) ? 1 : int'(rom[m_idx[k] % 16]);
      m_on[k] = (m_d[k] > g) ? m_d[k] - g : 1;
      m_t[k] = 1;
      e_st[k] = 1;
    end else if (!pause) begin
      if (m_t[k] == m_d[k]) begin
        if (m_idx[k] != m_len[k] - 1) begin
          m_idx[k]++; m_t[k] = 0;
        end else if (loop_en) begin
          m_idx[k] = 0; m_t[k] = 0;
        end else begin
          e_done[k] = 1; m_idx[k] = 0; m_busy[k] = 0;
        end
      end else begin
        m_t[k]++;
      end
    end
    e_on[k] = (m_busy[k] != 0 && m_t[k] >= 1 && m_t[k] <= m_on[k] && !pause) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      string p;
      p = (k == 0) ? "g2" : "g0";
      chk({p, ".model.note_index"}, int'(w_idx[k]), m_idx[k]);
      chk({p, ".model.note_on"},    int'(w_on[k]),   e_on[k]);
      chk({p, ".model.note_start"}, int'(w_st[k]),   e_st[k]);
      chk({p, ".model.song_done"},  int'(w_done[k]), e_done[k]);
      chk({p, ".model.busy"},       int'(w_busy[k]), m_busy[k]);
    end
  endtask

  task automatic clear_in();
    play = 0; stop = 0; pause = 0; rst = 0;
  endtask

  task automatic wait_idle();
    int n;
    clear_in();
    n = 0;
    while ((w_busy[0] || w_busy[1]) && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle.busy", int'(w_busy[0] | w_busy[1]), 0);
  endtask

  function automatic vec_t mk(bit p, bit s, bit pa, bit lp, int len, int idx,
                              bit on, bit st, bit dn, bit bs);
    vec_t v;
    v.play = p; v.stop = s; v.pause = pa; v.loop_en = lp; v.len = len; v.idx = idx;
    v.on = on; v.st = st; v.done = dn; v.busy = bs;
    return v;
  endfunction

  task automatic run_vec(input int lo, input int hi, input int mask, input string nm);
    for (int i = lo; i <= hi; i++) begin
      play = vt[i].play; stop = vt[i].stop; pause = vt[i].pause;
      loop_en = vt[i].loop_en; song_len = 11'(vt[i].len);
      tick();
      for (int k = 0; k < 2; k++) begin
        if (mask[k]) begin
          chk($sformatf("%s[%0d].dut%0d.note_index", nm, i - lo, k), int'(w_idx[k]), vt[i].idx);
          chk($sformatf("%s[%0d].dut%0d.note_on", nm, i - lo, k), int'(w_on[k]), int'(vt[i].on));
          chk($sformatf("%s[%0d].dut%0d.note_start", nm, i - lo, k), int'(w_st[k]), int'(vt[i].st));
          chk($sformatf("%s[%0d].dut%0d.song_done", nm, i - lo, k), int'(w_done[k]), int'(vt[i].done));
          chk($sformatf("%s[%0d].dut%0d.busy", nm, i - lo, k), int'(w_busy[k]), int'(vt[i].busy));
        end
      end
    end
    clear_in();
  endtask

  initial begin
    int n_busy, n_on, n_done;
    bit seen;
    int idxq[$];

    // Basic song on the gap-2 instance: durations 5,1,3.
    vt.push_back(mk(1,0,0,0,3, 0, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 0, 1,1,0,1));
    vt.push_back(mk(0,0,0,0,3, 0, 1,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 0, 1,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 0, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 0, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 1, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 1, 1,1,0,1));
    vt.push_back(mk(0,0,0,0,3, 2, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 2, 1,1,0,1));
    vt.push_back(mk(0,0,0,0,3, 2, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 2, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,3, 0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,3, 0, 0,0,0,0));
    // Zero-duration two-note song, identical on both instances.
    vt.push_back(mk(1,0,0,0,2, 0, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,2, 0, 1,1,0,1));
    vt.push_back(mk(0,0,0,0,2, 1, 0,0,0,1));
    vt.push_back(mk(0,0,0,0,2, 1, 1,1,0,1));
    vt.push_back(mk(0,0,0,0,2, 0, 0,0,1,0));
    vt.push_back(mk(0,0,0,0,2, 0, 0,0,0,0));

    for (int i = 0; i < 16; i++) rom[i] = 29'd0;
    clear_in(); loop_en = 0; song_len = 11'd0;
    rst = 1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset.note_index", int'(w_idx[k]), 0);
      chk("reset.note_on", int'(w_on[k]), 0);
      chk("reset.note_start", int'(w_st[k]), 0);
      chk("reset.song_done", int'(w_done[k]), 0);
      chk("reset.busy", int'(w_busy[k]), 0);
    end
    rst = 0;
    tick();

    rom[0] = 29'd5; rom[1] = 29'd1; rom[2] = 29'd3;
    run_vec(0, 13, 1, "basic");
    wait_idle();
    rom[0] = 29'd0; rom[1] = 29'd0;
    run_vec(14, 19, 3, "zerodur");
    wait_idle();

    // Pause for 4 cycles in the middle of a 10-cycle note.
    rom[0] = 29'd10; song_len = 11'd1; play = 1;
    tick();
    play = 0;
    n_busy = int'(w_busy[1]); n_on = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      pause = (c >= 3 && c < 7);
      tick();
      n_busy += int'(w_busy[1]);
      n_on += int'(w_on[1]);
      if (w_done[1]) seen = 1;
    end
    pause = 0;
    chk("pause.done_seen", int'(seen), 1);
    chk("pause.period", n_busy, 15);
    chk("pause.on_cycles", n_on, 10);
    wait_idle();

    // Loop two notes, then stop.
    rom[0] = 29'd2; rom[1] = 29'd3; song_len = 11'd2; loop_en = 1; play = 1;
    tick();
    play = 0; n_done = 0;
    for (int c = 0; c < 60 && idxq.size() < 4; c++) begin
      tick();
      if (w_st[0]) idxq.push_back(int'(w_idx[0]));
      n_done += int'(w_done[0]);
    end
    chk("loop.notes", idxq.size(), 4);
    for (int i = 0; i < 4 && i < idxq.size(); i++) chk($sformatf("loop.idx%0d", i), idxq[i], i % 2);
    chk("loop.no_done", n_done, 0);
    stop = 1;
    tick();
    stop = 0;
    chk("stop.busy", int'(w_busy[0]), 0);
    chk("stop.note_on", int'(w_on[0]), 0);
    chk("stop.note_index", int'(w_idx[0]), 0);
    chk("stop.song_done", int'(w_done[0]), 0);
    tick();
    chk("stop.song_done_after", int'(w_done[0]), 0);
    loop_en = 0;

    // Empty song.
    song_len = 11'd0; play = 1;
    tick();
    play = 0;
    chk("empty.song_done", int'(w_done[0]), 1);
    chk("empty.busy", int'(w_busy[0]), 0);
    tick();
    chk("empty.song_done_once", int'(w_done[0]), 0);
    chk("empty.busy_after", int'(w_busy[0]), 0);

    // play and stop together.
    song_len = 11'd3; play = 1; stop = 1;
    tick();
    clear_in();
    chk("playstop.busy", int'(w_busy[0]), 0);
    chk("playstop.song_done", int'(w_done[0]), 0);

    // play while busy is ignored.
    rom[0] = 29'd4; rom[1] = 29'd4; song_len = 11'd2; play = 1;
    tick();
    play = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("busyplay.pre_idx", int'(w_idx[0]), 1);
    song_len = 11'd5; play = 1;
    tick();
    play = 0;
    chk("busyplay.idx", int'(w_idx[0]), 1);
    chk("busyplay.busy", int'(w_busy[0]), 1);
    n_done = 0;
    for (int c = 0; c < 30 && n_done == 0; c++) begin
      tick();
      n_done += int'(w_done[0]);
    end
    chk("busyplay.done", n_done, 1);
    wait_idle();

    // Reset in the middle of a gap.
    rom[0] = 29'd5; song_len = 11'd1; play = 1;
    tick();
    play = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("rstgap.in_gap_on", int'(w_on[0]), 0);
    chk("rstgap.in_gap_busy", int'(w_busy[0]), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rstgap.note_index", int'(w_idx[0]), 0);
    chk("rstgap.note_on", int'(w_on[0]), 0);
    chk("rstgap.note_start", int'(w_st[0]), 0);
    chk("rstgap.song_done", int'(w_done[0]), 0);
    chk("rstgap.busy", int'(w_busy[0]), 0);
    rom[0] = 29'd3; play = 1;
    tick();
    play = 0;
    chk("rstgap.replay_busy", int'(w_busy[0]), 1);
    chk("rstgap.replay_idx", int'(w_idx[0]), 0);
    wait_idle();

    // Random traffic against the model.
    for (int i = 0; i < 16; i++) rom[i] = 29'($urandom_range(0, 7));
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      play  = ($urandom_range(0, 9) == 0);
      pause = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      song_len = ($urandom_range(0, 9) == 0) ? 11'd0 : 11'($urandom_range(1, 5));
      tick();
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
